// File: rtl/sqrt_batch_controller_if.sv
// Host and square-root-unit signals of the sqrt batch controller.
// master = host plus sqrt unit, slave = the controller itself.
interface sqrt_batch_controller_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              Go;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [7:0]        WrData;
    logic [ADDR_W-1:0] RdAddr;
    logic [3:0]        RdData;
    logic              St;
    logic [7:0]        N;
    logic              Done;
    logic [3:0]        Sqrt;
    logic              Busy;
    logic              BatchDone;
    logic [ADDR_W:0]   Count;

    modport master (
        output Go, WrEn, WrAddr, WrData, RdAddr, Done, Sqrt,
        input  RdData, St, N, Busy, BatchDone, Count
    );

    modport slave (
        input  Go, WrEn, WrAddr, WrData, RdAddr, Done, Sqrt,
        output RdData, St, N, Busy, BatchDone, Count
    );
endinterface

// File: rtl/sqrt_batch_controller.sv
// Feeds a batch of 8-bit operands to square_root_unit over St/Done and
// stores each 4-bit result in a host-readable result memory.
module sqrt_batch_controller #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned ADDR_W      = 4
) (
    input logic                    Clock,
    input logic                    ResetN,
    sqrt_batch_controller_if.slave bus
);
    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 4;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE,
        FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              last;

    logic [OP_W-1:0]  opmem  [NUM_VECTORS];
    logic [RES_W-1:0] resmem [NUM_VECTORS];

    assign last       = (idx == ADDR_W'(NUM_VECTORS - 1));
    assign bus.RdData = resmem[bus.RdAddr];

    // Memories carry no reset so results survive ResetN
    always_ff @(posedge Clock) begin
        if (state == IDLE && bus.WrEn) begin
            opmem[bus.WrAddr] <= bus.WrData;
        end
        if (state == REQ && bus.Done) begin
            resmem[idx] <= bus.Sqrt;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state         <= IDLE;
            idx           <= '0;
            bus.St        <= 1'b0;
            bus.N         <= '0;
            bus.Busy      <= 1'b0;
            bus.BatchDone <= 1'b0;
            bus.Count     <= '0;
        end else begin
            bus.BatchDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Go) begin
                        idx       <= '0;
                        bus.Count <= '0;
                        bus.Busy  <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // A Done left high from a previous request must clear first
                    bus.N  <= opmem[idx];
                    bus.St <= 1'b0;
                    if (!bus.Done) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.Done) begin
                        bus.Count <= bus.Count + CNT_W'(1);
                        bus.St    <= 1'b0;
                        state     <= RELEASE;
                    end else begin
                        bus.St <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!bus.Done) begin
                        if (last) begin
                            bus.BatchDone <= 1'b1;
                            state         <= FINISH;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= SETUP;
                        end
                    end
                end
                FINISH: begin
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_batch_controller.sv
// Bench for sqrt_batch_controller: behavioural sqrt unit, handshake
// monitor, and an expected-value queue drained against DUT outputs.
module tb_sqrt_batch_controller;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NV     = 16;

    logic Clock = 1'b0;
    logic ResetN;

    sqrt_batch_controller_if #(.ADDR_W(ADDR_W)) bus ();

    sqrt_batch_controller #(.NUM_VECTORS(NV), .ADDR_W(ADDR_W)) dut (
        .Clock (Clock),
        .ResetN(ResetN),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int pass_cnt = 0;
    int total_cnt = 0;

    int lat = 2;
    int hold = 1;
    bit stale_hold = 1'b0;
    logic [7:0] obs_n[$];

    int   mon_st_done = 0;
    int   mon_early_drop = 0;
    int   mon_n_unstable = 0;
    logic prev_st = 1'b0;
    logic [7:0] prev_n = 8'h00;

    function automatic logic [3:0] isqrt(input logic [7:0] v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return 4'(r);
    endfunction

    // Behavioural square_root_unit: Done rises lat cycles after St, held hold cycles
    initial begin : sqrt_model
        int m_state;
        int m_cnt;
        int m_h;
        logic [7:0] m_op;
        m_state = 0; m_cnt = 0; m_h = 0; m_op = 8'h00;
        bus.Done = 1'b0;
        bus.Sqrt = 4'h0;
        forever begin
            @(negedge Clock);
            if (ResetN !== 1'b1) begin
                m_state = 0; bus.Done = 1'b0;
            end else if (stale_hold) begin
                m_state = 0; bus.Done = 1'b1; bus.Sqrt = 4'h0;
            end else begin
                case (m_state)
                    0: begin
                        bus.Done = 1'b0;
                        if (bus.St === 1'b1) begin
                            m_op = bus.N; obs_n.push_back(bus.N);
                            m_cnt = 1; m_state = 1;
                        end
                    end
                    1: begin
                        m_cnt++;
                        if (m_cnt >= lat) begin
                            bus.Done = 1'b1; bus.Sqrt = isqrt(m_op);
                            m_h = 1; m_state = 2;
                        end
                    end
                    default: begin
                        m_h++;
                        if (m_h > hold) begin
                            bus.Done = 1'b0; m_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Handshake monitor sampled just after each rising edge
    always @(posedge Clock) begin
        #1;
        if (ResetN === 1'b1) begin
            if (bus.St === 1'b1 && bus.Done === 1'b1) mon_st_done++;
            if (prev_st === 1'b1 && bus.St === 1'b0 && bus.Done !== 1'b1) mon_early_drop++;
            if (prev_st === 1'b1 && bus.St === 1'b1 && bus.N !== prev_n) mon_n_unstable++;
        end
        prev_st = bus.St;
        prev_n  = bus.N;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic load_op(input logic [3:0] a, input logic [7:0] d);
        @(negedge Clock);
        bus.WrEn = 1'b1; bus.WrAddr = a; bus.WrData = d;
        @(negedge Clock);
        bus.WrEn = 1'b0;
    endtask

    task automatic go_pulse();
        @(negedge Clock);
        bus.Go = 1'b1;
        @(negedge Clock);
        bus.Go = 1'b0;
    endtask

    task automatic read_res(input logic [3:0] a, output logic [3:0] d);
        @(negedge Clock);
        bus.RdAddr = a;
        #1 d = bus.RdData;
    endtask

    task automatic run_until_idle(input int budget, output int pulses, output bit busy_ok,
                                  output bit restarted, output bit timed_out);
        logic bd_busy;
        logic after_busy;
        bit   after_taken;
        logic [4:0] prev_cnt;
        pulses = 0; busy_ok = 1'b0; restarted = 1'b0; timed_out = 1'b1;
        bd_busy = 1'b0; after_busy = 1'bx; after_taken = 1'b0;
        prev_cnt = bus.Count;
        for (int n = 0; n < budget; n++) begin
            @(negedge Clock);
            if (bus.Count < prev_cnt) restarted = 1'b1;
            prev_cnt = bus.Count;
            if (bus.BatchDone === 1'b1) begin
                pulses++; bd_busy = bus.Busy;
            end else if (pulses > 0) begin
                if (!after_taken) begin after_busy = bus.Busy; after_taken = 1'b1; end
                if (bus.Busy === 1'b0) begin timed_out = 1'b0; break; end
            end
        end
        repeat (4) begin
            @(negedge Clock);
            if (bus.BatchDone === 1'b1) pulses++;
        end
        busy_ok = (bd_busy === 1'b1) && (after_busy === 1'b0);
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        bus.Go = 1'b0; bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrData = '0; bus.RdAddr = '0;
        repeat (2) @(negedge Clock);
        total_cnt++; if (bus.St !== 1'b0) $display("FAIL reset_st: got %b expected 0", bus.St); else pass_cnt++;
        total_cnt++; if (bus.N !== 8'h00) $display("FAIL reset_n: got %0h expected 0", bus.N); else pass_cnt++;
        total_cnt++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.Busy); else pass_cnt++;
        total_cnt++; if (bus.BatchDone !== 1'b0) $display("FAIL reset_batchdone: got %b expected 0", bus.BatchDone); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", bus.Count); else pass_cnt++;
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    task automatic test_full_batch();
        logic [7:0] ops   [16] = '{8'd0, 8'd1, 8'd4, 8'd15, 8'd16, 8'd63, 8'd64, 8'd100,
                                   8'd143, 8'd144, 8'd168, 8'd169, 8'd224, 8'd225, 8'd254, 8'd255};
        logic [3:0] roots [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd10,
                                   4'd11, 4'd12, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15};
        logic [3:0] exp_res[$];
        logic [7:0] exp_n[$];
        logic [3:0] d, e;
        logic [7:0] en, gn;
        int pulses; bit busy_ok, restarted, to;
        lat = 2; hold = 1;
        for (int i = 0; i < 16; i++) load_op(4'(i), ops[i]);
        obs_n.delete();
        for (int i = 0; i < 16; i++) begin
            exp_n.push_back(ops[i]);
            exp_res.push_back(roots[i]);
        end
        go_pulse();
        run_until_idle(2000, pulses, busy_ok, restarted, to);
        total_cnt++; if (to) $display("FAIL full_timeout: got timeout expected batch end"); else pass_cnt++;
        total_cnt++; if (pulses != 1) $display("FAIL full_batchdone_pulses: got %0d expected 1", pulses); else pass_cnt++;
        total_cnt++; if (!busy_ok) $display("FAIL full_busy_fall: got %b expected 1", busy_ok); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd16) $display("FAIL full_count: got %0d expected 16", bus.Count); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            read_res(4'(i), d);
            e = exp_res.pop_front();
            total_cnt++; if (d !== e) $display("FAIL full_rd[%0d]: got %0d expected %0d", i, d, e); else pass_cnt++;
        end
        total_cnt++; if (obs_n.size() != 16) $display("FAIL full_n_count: got %0d expected 16", obs_n.size()); else pass_cnt++;
        while (exp_n.size() > 0) begin
            en = exp_n.pop_front();
            gn = (obs_n.size() > 0) ? obs_n.pop_front() : 8'hxx;
            total_cnt++; if (gn !== en) $display("FAIL full_n_order: got %0h expected %0h", gn, en); else pass_cnt++;
        end
    endtask

    task automatic test_handshake();
        int hi, lo, pulses; bit busy_ok, restarted, to;
        logic [7:0] first_n;
        lat = 7; hold = 3;
        load_op(4'd0, 8'd200);
        obs_n.delete();
        mon_st_done = 0; mon_early_drop = 0; mon_n_unstable = 0;
        go_pulse();
        total_cnt++; if (bus.Busy !== 1'b1) $display("FAIL hs_busy_rise: got %b expected 1", bus.Busy); else pass_cnt++;
        total_cnt++; if (bus.St !== 1'b0) $display("FAIL hs_st_setup: got %b expected 0", bus.St); else pass_cnt++;
        @(negedge Clock);
        total_cnt++; if (bus.N !== 8'd200) $display("FAIL hs_n_valid: got %0d expected 200", bus.N); else pass_cnt++;
        @(negedge Clock);
        total_cnt++; if (bus.St !== 1'b1) $display("FAIL hs_st_rise: got %b expected 1", bus.St); else pass_cnt++;
        hi = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clock);
            if (bus.St !== 1'b1) break;
            hi++;
        end
        lo = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clock);
            if (bus.St === 1'b1) break;
            lo++;
        end
        total_cnt++; if (hi != 7) $display("FAIL hs_st_high_cycles: got %0d expected 7", hi); else pass_cnt++;
        total_cnt++; if (lo != 5) $display("FAIL hs_st_gap_cycles: got %0d expected 5", lo); else pass_cnt++;
        run_until_idle(4000, pulses, busy_ok, restarted, to);
        total_cnt++; if (to) $display("FAIL hs_timeout: got timeout expected batch end"); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd16) $display("FAIL hs_count: got %0d expected 16", bus.Count); else pass_cnt++;
        total_cnt++; if (mon_st_done != 0) $display("FAIL hs_st_with_done: got %0d expected 0", mon_st_done); else pass_cnt++;
        total_cnt++; if (mon_early_drop != 0) $display("FAIL hs_st_early_drop: got %0d expected 0", mon_early_drop); else pass_cnt++;
        total_cnt++; if (mon_n_unstable != 0) $display("FAIL hs_n_unstable: got %0d expected 0", mon_n_unstable); else pass_cnt++;
        first_n = (obs_n.size() > 0) ? obs_n.pop_front() : 8'hxx;
        total_cnt++; if (first_n !== 8'd200) $display("FAIL hs_first_n: got %0h expected c8", first_n); else pass_cnt++;
        lat = 2; hold = 1;
    endtask

    task automatic test_stale_done();
        int pulses; bit busy_ok, restarted, to;
        stale_hold = 1'b1;
        repeat (2) @(negedge Clock);
        go_pulse();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            total_cnt++; if (bus.St !== 1'b0) $display("FAIL stale_st[%0d]: got %b expected 0", i, bus.St); else pass_cnt++;
        end
        total_cnt++; if (bus.Busy !== 1'b1) $display("FAIL stale_busy: got %b expected 1", bus.Busy); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd0) $display("FAIL stale_count_hold: got %0d expected 0", bus.Count); else pass_cnt++;
        stale_hold = 1'b0;
        run_until_idle(2000, pulses, busy_ok, restarted, to);
        total_cnt++; if (to) $display("FAIL stale_timeout: got timeout expected batch end"); else pass_cnt++;
        total_cnt++; if (pulses != 1) $display("FAIL stale_pulses: got %0d expected 1", pulses); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd16) $display("FAIL stale_count: got %0d expected 16", bus.Count); else pass_cnt++;
    endtask

    task automatic test_busy_writes();
        int pulses; bit busy_ok, restarted, to, reached;
        logic [4:0] cnt_before;
        logic [3:0] d;
        load_op(4'd15, 8'd255);
        go_pulse();
        reached = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge Clock);
            if (bus.Count >= 5'd3) begin reached = 1'b1; break; end
        end
        total_cnt++; if (!reached) $display("FAIL bw_progress: got count %0d expected >=3", bus.Count); else pass_cnt++;
        cnt_before = bus.Count;
        bus.WrEn = 1'b1; bus.WrAddr = 4'd15; bus.WrData = 8'h09; bus.Go = 1'b1;
        @(negedge Clock);
        bus.WrEn = 1'b0; bus.Go = 1'b0;
        total_cnt++; if (bus.Count < cnt_before) $display("FAIL bw_no_restart: got count %0d expected >=%0d", bus.Count, cnt_before); else pass_cnt++;
        run_until_idle(2000, pulses, busy_ok, restarted, to);
        total_cnt++; if (to || restarted) $display("FAIL bw_run: got timeout=%b restart=%b expected 0 0", to, restarted); else pass_cnt++;
        total_cnt++; if (pulses != 1) $display("FAIL bw_pulses: got %0d expected 1", pulses); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd16) $display("FAIL bw_count: got %0d expected 16", bus.Count); else pass_cnt++;
        read_res(4'd15, d);
        total_cnt++; if (d !== 4'd15) $display("FAIL bw_res15_orig: got %0d expected 15", d); else pass_cnt++;
        load_op(4'd15, 8'h09);
        go_pulse();
        run_until_idle(2000, pulses, busy_ok, restarted, to);
        total_cnt++; if (to) $display("FAIL bw_fresh_timeout: got timeout expected batch end"); else pass_cnt++;
        read_res(4'd15, d);
        total_cnt++; if (d !== 4'd3) $display("FAIL bw_res15_new: got %0d expected 3", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_batch();
        logic [7:0] ops [5] = '{8'd81, 8'd100, 8'd121, 8'd144, 8'd169};
        logic [3:0] exp_res[$];
        logic [3:0] d, e;
        int pulses; bit busy_ok, restarted, to, reached;
        lat = 3; hold = 1;
        for (int i = 0; i < 5; i++) begin
            load_op(4'(i), ops[i]);
            exp_res.push_back(4'(9 + i));
        end
        go_pulse();
        reached = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge Clock);
            if (bus.Count === 5'd5 && bus.St === 1'b1) begin reached = 1'b1; break; end
        end
        total_cnt++; if (!reached) $display("FAIL rst_progress: got count %0d expected 5 with St", bus.Count); else pass_cnt++;
        #2 ResetN = 1'b0;
        #1;
        total_cnt++; if (bus.St !== 1'b0) $display("FAIL rst_async_st: got %b expected 0", bus.St); else pass_cnt++;
        total_cnt++; if (bus.Busy !== 1'b0) $display("FAIL rst_async_busy: got %b expected 0", bus.Busy); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd0) $display("FAIL rst_async_count: got %0d expected 0", bus.Count); else pass_cnt++;
        total_cnt++; if (bus.N !== 8'h00) $display("FAIL rst_async_n: got %0h expected 0", bus.N); else pass_cnt++;
        @(negedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            read_res(4'(i), d);
            e = exp_res.pop_front();
            total_cnt++; if (d !== e) $display("FAIL rst_keep_rd[%0d]: got %0d expected %0d", i, d, e); else pass_cnt++;
        end
        lat = 2; hold = 1;
        obs_n.delete();
        go_pulse();
        run_until_idle(2000, pulses, busy_ok, restarted, to);
        total_cnt++; if (to) $display("FAIL rst_rerun_timeout: got timeout expected batch end"); else pass_cnt++;
        total_cnt++; if (bus.Count !== 5'd16) $display("FAIL rst_rerun_count: got %0d expected 16", bus.Count); else pass_cnt++;
        total_cnt++; if (obs_n.size() != 16) $display("FAIL rst_rerun_ops: got %0d expected 16", obs_n.size()); else pass_cnt++;
        read_res(4'd5, d);
        total_cnt++; if (d !== 4'd7) $display("FAIL rst_rerun_rd5: got %0d expected 7", d); else pass_cnt++;
    endtask

    initial begin
        ResetN = 1'b0;
        test_reset();
        test_full_batch();
        test_handshake();
        test_stale_done();
        test_busy_writes();
        test_reset_mid_batch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
